// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage holding one entry (SKID=0) or two entries
// (SKID=1, main plus skid register). With SKID=1 the upstream ready is a pure
// register, which breaks the combinational ready chain between pipeline stages.
// Entries leave in acceptance order. Whenever no live entry is held, the output
// data shows the BUBBLE value.
//
// Parameters
//   WIDTH  : payload width in bits (1..1024)
//   SKID   : 0 = single-entry stage, 1 = two-entry skid stage
//   BUBBLE : value driven on o_out_data while o_out_valid=0
// Ports
//   i_clk       : clock; all state changes on its rising edge
//   i_reset     : synchronous active-high reset; highest priority
//   i_flush     : drops every held entry and any same-cycle input
//   i_in_valid  : upstream offers i_in_data
//   o_in_ready  : stage accepts data this cycle
//   i_in_data   : upstream payload
//   o_out_valid : o_out_data holds a live entry
//   i_out_ready : downstream consumes this cycle
//   o_out_data  : head payload, or BUBBLE when not valid
//   o_count     : number of live entries
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int               WIDTH  = 32,
   parameter int               SKID   = 1,
   parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [1:0]       o_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;
   logic             valid_r;
   logic [1:0]       count_r;
   logic             in_ready_r;
   logic             accept_s;
   logic             consume_s;

   assign consume_s = valid_r & i_out_ready;
   assign accept_s  = i_in_valid & o_in_ready & ~i_flush;

   generate
      if (SKID == 0) begin : g_single
         // Single entry: a slot frees up in the same cycle the head is consumed.
         assign o_in_ready = ~valid_r | i_out_ready;
      end else begin : g_skid
         // Skid stage: ready comes straight from a flop.
         assign o_in_ready = in_ready_r;
      end
   endgenerate

   // The head entry lives in main_r, so the output data and valid come
   // directly from registers.
   assign o_out_data  = main_r;
   assign o_out_valid = valid_r;
   assign o_count     = count_r;

   // Stage state machine. main_r holds the head entry, and skid_r holds the
   // second entry. A register is reloaded with BUBBLE when its entry leaves,
   // so the output shows BUBBLE whenever the stage is empty.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r    <= ST_EMPTY;
         main_r     <= BUBBLE;
         skid_r     <= BUBBLE;
         valid_r    <= 1'b0;
         count_r    <= 2'd0;
         in_ready_r <= 1'b0;
      end else if (i_flush) begin
         state_r    <= ST_EMPTY;
         main_r     <= BUBBLE;
         skid_r     <= BUBBLE;
         valid_r    <= 1'b0;
         count_r    <= 2'd0;
         in_ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               in_ready_r <= 1'b1;
               if (accept_s) begin
                  main_r  <= i_in_data;
                  valid_r <= 1'b1;
                  count_r <= 2'd1;
                  state_r <= ST_HALF;
               end else begin
                  state_r <= ST_EMPTY;
               end
            end
            ST_HALF: begin
               if (accept_s && consume_s) begin
                  main_r <= i_in_data;
               end else if (accept_s && (SKID != 0)) begin
                  // Downstream stalled: park the new entry behind the head.
                  skid_r     <= i_in_data;
                  count_r    <= 2'd2;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_FULL;
               end else if (consume_s) begin
                  main_r  <= BUBBLE;
                  valid_r <= 1'b0;
                  count_r <= 2'd0;
                  state_r <= ST_EMPTY;
               end else begin
                  state_r <= ST_HALF;
               end
            end
            ST_FULL: begin
               if (consume_s) begin
                  main_r     <= skid_r;
                  skid_r     <= BUBBLE;
                  count_r    <= 2'd1;
                  in_ready_r <= 1'b1;
                  state_r    <= ST_HALF;
               end else begin
                  state_r <= ST_FULL;
               end
            end
            default: begin
               state_r    <= ST_EMPTY;
               main_r     <= BUBBLE;
               skid_r     <= BUBBLE;
               valid_r    <= 1'b0;
               count_r    <= 2'd0;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

endmodule
